// File: rtl/reg_rx_serie32_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding and shift-direction codes.
package reg_rx_serie32_pkg;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'b00,
      RX_DATA   = 2'b01,
      RX_PARITY = 2'b10,
      RX_STOP   = 2'b11
   } rx_state_e;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/reg_rx_serie32_desp_in4.sv
// 4-bit bidirectional serial-in slice; S_L/S_R expose the end bits so slices can be chained.
module desp_in4
   import reg_rx_serie32_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_L,
   input  logic       ENB,
   input  logic       DIR,
   input  logic       S_IN,
   output logic       S_L,
   output logic       S_R,
   output logic [3:0] Q
);

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         Q <= '0;
      end else if (ENB) begin
         if (DIR == DIR_MSB) begin
            Q <= {Q[2:0], S_IN};
         end else begin
            Q <= {S_IN, Q[3:1]};
         end
      end
   end

   assign S_L = Q[3];
   assign S_R = Q[0];

endmodule

// File: rtl/reg_rx_serie32.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits (LSB- or MSB-first),
// optional even parity, stop bit; delivers the word on Q32 with a VALID pulse.
module reg_rx_serie32
   import reg_rx_serie32_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RST_L,
   input  logic             ENB,
   input  logic             DIR,
   input  logic             S_IN,
   output logic [WIDTH-1:0] Q32,
   output logic             VALID,
   output logic             PERR,
   output logic             FERR,
   output logic             BUSY
);

   localparam int unsigned SLICES = WIDTH / 4;
   localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   rx_state_e        state, state_nxt;
   logic [CW-1:0]    count;
   logic             acc;
   logic             perr_q;
   logic             dir_q;
   logic             shift_en;
   logic [WIDTH-1:0] shreg;
   logic [SLICES-1:0] s_l, s_r, s_in_slice;
   logic             chain_end_unused;

   // The serial bit enters the top slice when shifting right and slice 0 when
   // shifting left; every other slice takes its neighbour's end bit.
   for (genvar k = 0; k < SLICES; k++) begin : g_slice
      logic from_lo, from_hi;

      if (k == 0) begin : g_lo_end
         assign from_lo = S_IN;
      end else begin : g_lo_link
         assign from_lo = s_l[k-1];
      end

      if (k == SLICES - 1) begin : g_hi_end
         assign from_hi = S_IN;
      end else begin : g_hi_link
         assign from_hi = s_r[k+1];
      end

      assign s_in_slice[k] = (dir_q == DIR_MSB) ? from_lo : from_hi;

      desp_in4 u_slice (
         .CLK   (CLK),
         .RST_L (RST_L),
         .ENB   (shift_en),
         .DIR   (dir_q),
         .S_IN  (s_in_slice[k]),
         .S_L   (s_l[k]),
         .S_R   (s_r[k]),
         .Q     (shreg[4*k +: 4])
      );
   end

   // Bits shifted off the far end of the chain are discarded.
   assign chain_end_unused = s_l[SLICES-1] ^ s_r[0];

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state <= RX_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (ENB && !S_IN) begin
               state_nxt = RX_DATA;
            end
         end
         RX_DATA: begin
            shift_en = ENB;
            if (ENB && (count == LAST_BIT)) begin
               state_nxt = PARITY_EN ? RX_PARITY : RX_STOP;
            end
         end
         RX_PARITY: begin
            if (ENB) begin
               state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (ENB) begin
               state_nxt = RX_IDLE;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         count  <= '0;
         acc    <= 1'b0;
         perr_q <= 1'b0;
         dir_q  <= DIR_LSB;
         Q32    <= '0;
         VALID  <= 1'b0;
         PERR   <= 1'b0;
         FERR   <= 1'b0;
         BUSY   <= 1'b0;
      end else begin
         VALID <= 1'b0;
         PERR  <= 1'b0;
         FERR  <= 1'b0;
         BUSY  <= (state_nxt != RX_IDLE);
         if (ENB) begin
            case (state)
               RX_IDLE: begin
                  if (!S_IN) begin
                     count  <= '0;
                     acc    <= 1'b0;
                     perr_q <= 1'b0;
                     dir_q  <= DIR;
                  end
               end
               RX_DATA: begin
                  count <= count + CW'(1);
                  acc   <= acc ^ S_IN;
               end
               RX_PARITY: begin
                  perr_q <= acc ^ S_IN;
               end
               RX_STOP: begin
                  if (S_IN) begin
                     Q32   <= shreg;
                     VALID <= 1'b1;
                     PERR  <= perr_q;
                  end else begin
                     FERR  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reg_rx_serie32.sv
// Directed bench for reg_rx_serie32: table of whole frames plus reset and idle sequences.
module tb_reg_rx_serie32;

   logic        CLK = 1'b0;
   logic        RST_L;
   logic        ENB;
   logic        DIR;
   logic        S_IN;
   logic [31:0] Q32;
   logic        VALID, PERR, FERR, BUSY;

   int tests    = 0;
   int failures = 0;
   int vcnt, pcnt, fcnt, busy_low;

   typedef struct {
      logic        dir;
      logic [31:0] data;
      logic        par;
      logic        stop;
      int          gap;
      logic        flip;
      logic        exp_valid;
      logic        exp_perr;
      logic        exp_ferr;
      logic [31:0] exp_q;
   } vec_t;

   vec_t vecs[9];

   reg_rx_serie32 #(.WIDTH(32), .PARITY_EN(1'b1)) dut (
      .CLK   (CLK),
      .RST_L (RST_L),
      .ENB   (ENB),
      .DIR   (DIR),
      .S_IN  (S_IN),
      .Q32   (Q32),
      .VALID (VALID),
      .PERR  (PERR),
      .FERR  (FERR),
      .BUSY  (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      vcnt += int'(VALID);
      pcnt += int'(PERR);
      fcnt += int'(FERR);
   endtask

   // gap cycles with ENB=0 and a garbage line value precede the strobe
   task automatic strobe(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         ENB  = 1'b0;
         S_IN = ~b;
         tick();
         if (BUSY !== 1'b1) busy_low++;
      end
      ENB  = 1'b1;
      S_IN = b;
      tick();
   endtask

   task automatic send_frame(input vec_t v);
      logic b;
      vcnt = 0; pcnt = 0; fcnt = 0; busy_low = 0;
      DIR = v.dir;
      strobe(1'b0, 0);
      for (int i = 0; i < 32; i++) begin
         b = v.dir ? v.data[31-i] : v.data[i];
         if (v.flip) DIR = ~v.dir;
         strobe(b, v.gap);
      end
      strobe(v.par, v.gap);
      strobe(v.stop, v.gap);
      DIR = v.dir;
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'hA5A5_0F0F, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[1] = '{1'b1, 32'h8000_0001, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0001};
      vecs[2] = '{1'b0, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0007};
      vecs[3] = '{1'b0, 32'h1234_5678, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678};
      vecs[4] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
      vecs[5] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[6] = '{1'b1, 32'hC0FF_EE00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC0FF_EE00};
      vecs[7] = '{1'b0, 32'h0000_FFFF, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF};
      vecs[8] = '{1'b1, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0007};

      RST_L = 1'b0; ENB = 1'b0; DIR = 1'b0; S_IN = 1'b1;
      vcnt = 0; pcnt = 0; fcnt = 0; busy_low = 0;
      #12;
      check("reset_q32",   Q32,   32'h0);
      check("reset_valid", VALID, 32'h0);
      check("reset_perr",  PERR,  32'h0);
      check("reset_ferr",  FERR,  32'h0);
      check("reset_busy",  BUSY,  32'h0);
      #20 RST_L = 1'b1;
      ENB = 1'b1;
      tick();
      tick();

      // frames run back-to-back: each start bit follows the previous stop strobe
      for (int n = 0; n < 9; n++) begin
         send_frame(vecs[n]);
         check($sformatf("v%0d_valid", n),  VALID,    32'(vecs[n].exp_valid));
         check($sformatf("v%0d_perr", n),   PERR,     32'(vecs[n].exp_perr));
         check($sformatf("v%0d_ferr", n),   FERR,     32'(vecs[n].exp_ferr));
         check($sformatf("v%0d_q32", n),    Q32,      vecs[n].exp_q);
         check($sformatf("v%0d_busy", n),   BUSY,     32'h0);
         check($sformatf("v%0d_vcount", n), vcnt,     32'(vecs[n].exp_valid));
         check($sformatf("v%0d_busygap", n), busy_low, 32'h0);
      end

      ENB = 1'b1; S_IN = 1'b1;
      tick();
      check("idle_valid_drop", VALID, 32'h0);
      check("idle_busy",       BUSY,  32'h0);
      check("idle_q32_hold",   Q32,   32'h0000_0007);

      vcnt = 0;
      DIR = 1'b0;
      strobe(1'b0, 0);
      for (int i = 0; i < 10; i++) strobe(1'b1, 0);
      check("midframe_busy", BUSY, 32'h1);
      #2 RST_L = 1'b0;
      #1;
      check("rst_mid_q32",   Q32,   32'h0);
      check("rst_mid_busy",  BUSY,  32'h0);
      check("rst_mid_valid", VALID, 32'h0);
      #10 RST_L = 1'b1;
      ENB = 1'b1; S_IN = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("rst_mid_nopulse", vcnt, 32'h0);
      check("rst_mid_idle",    BUSY, 32'h0);

      send_frame('{1'b1, 32'h0000_FFFF, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF});
      check("post_rst_valid", VALID, 32'h1);
      check("post_rst_q32",   Q32,   32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
